// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS-485 half-duplex link controller.
package rs485_pkg;

  // Bus direction: listening, driving lead-in guard, shifting a frame out, driving tail guard.
  typedef enum logic [1:0] {LISTEN, LEAD, SEND, TAIL} dir_state_t;

  // Receive deserialiser: waiting, verifying start bit, sampling data, sampling stop.
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs485_rx_deser.sv
// Receive side of the half-duplex link: synchronises R, detects start
// edges and deserialises 8N1 frames. Only active while the receiver is
// enabled; while it is disabled the line is treated as idle-high.
module rs485_rx_deser
  import rs485_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       r,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_idle,
  output logic       r_s,
  output logic       r_fall
);

  localparam int BCW = cnt_width(CLK_DIV);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLK_DIV / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLK_DIV - 1);
  localparam logic [3:0]     IDX_LAST  = 4'(DATA_BITS - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            r_prev_q, r_prev_d;
  rx_state_t       state_q, state_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_frame_err_q, rx_frame_err_d;
  logic            err_wait_q, err_wait_d;

  // Two-flop synchroniser; a disabled receiver (R floating) is seen as constant 1.
  always_comb begin
    sync1_d  = rx_en ? r       : 1'b1;
    sync2_d  = rx_en ? sync1_q : 1'b1;
    r_s      = rx_en ? sync2_q : 1'b1;
    r_prev_d = r_s;
    r_fall   = r_prev_q & ~r_s;
  end

  // Frame deserialiser: mid-bit sampling, LSB first, stop-bit check.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    err_wait_d     = err_wait_q;
    if (!rx_en) begin
      // Leaving LISTEN drops any partial frame.
      state_d    = R_IDLE;
      bit_cnt_d  = '0;
      bit_idx_d  = '0;
      err_wait_d = 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (r_fall) begin
            state_d   = R_START;
            bit_cnt_d = '0;
          end
        end
        R_START: begin
          if (bit_cnt_q == HALF_LAST) begin
            bit_cnt_d = '0;
            bit_idx_d = '0;
            // A line back high at mid-start is a glitch, not a frame.
            state_d   = r_s ? R_IDLE : R_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        R_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            shift_d   = {r_s, shift_q[7:1]};
            if (bit_idx_q == IDX_LAST) begin
              state_d = R_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        R_STOP: begin
          if (err_wait_q) begin
            // After a bad stop bit, hold off until the line returns high.
            if (r_s) begin
              state_d    = R_IDLE;
              err_wait_d = 1'b0;
            end
          end else if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (r_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = R_IDLE;
            end else begin
              rx_frame_err_d = 1'b1;
              err_wait_d     = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        default: state_d = R_IDLE;
      endcase
    end
  end

  // Register synchroniser, deserialiser state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      r_prev_q       <= 1'b1;
      state_q        <= R_IDLE;
      bit_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      err_wait_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      r_prev_q       <= r_prev_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      err_wait_q     <= err_wait_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_idle      = (state_q == R_IDLE);

endmodule

// File: rtl/rs485_hdx_ctrl.sv
// Half-duplex RS-485 link controller. Owns the transceiver DE/RE_n/D pins,
// arbitrates bus direction (receive always wins) and serialises 8N1 frames
// with DE lead-in and tail guard times.
// Handshake: a byte is taken on a rising edge where tx_valid && tx_ready;
// tx_ready never depends on tx_valid, and there is no second TX buffer.
module rs485_hdx_ctrl
  import rs485_pkg::*;
#(
  parameter int CLK_DIV   = 868,
  parameter int DE_LEAD   = 100,
  parameter int DE_TAIL   = 100,
  parameter int IDLE_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       de,
  output logic       re_n,
  output logic       d,
  input  logic       r
);

  localparam int IDLE_MAX_I  = IDLE_BITS * CLK_DIV;
  localparam int GUARD_MAX_I = (DE_LEAD > DE_TAIL) ? DE_LEAD : DE_TAIL;
  localparam int ICW = cnt_width(IDLE_MAX_I + 1);
  localparam int GCW = cnt_width(GUARD_MAX_I + 1);
  localparam int BCW = cnt_width(CLK_DIV);

  localparam logic [ICW-1:0] IDLE_MAX   = ICW'(IDLE_MAX_I);
  localparam logic [GCW-1:0] LEAD_LAST  = GCW'(DE_LEAD - 1);
  localparam logic [GCW-1:0] TAIL_LAST  = GCW'(DE_TAIL - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(CLK_DIV - 1);
  localparam logic [3:0]     FRAME_LAST = 4'(FRAME_BITS - 1);

  dir_state_t                state_q, state_d;
  logic                      de_q, de_d;
  logic                      re_n_q, re_n_d;
  logic                      d_q, d_d;
  logic [ICW-1:0]            idle_cnt_q, idle_cnt_d;
  logic [GCW-1:0]            guard_cnt_q, guard_cnt_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]                bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]     frame_q, frame_d;

  logic rx_en;
  logic rx_idle;
  logic r_s;
  logic r_fall;

  assign rx_en = ~re_n_q;

  rs485_rx_deser #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_en        (rx_en),
    .r            (r),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_idle      (rx_idle),
    .r_s          (r_s),
    .r_fall       (r_fall)
  );

  // A start edge seen this cycle blocks TX, so receive wins any tie.
  always_comb begin
    tx_ready = (state_q == LISTEN) && (idle_cnt_q == IDLE_MAX) && rx_idle && !r_fall;
  end

  // Direction sequencing: quiet-bus check, lead guard, frame shift-out, tail guard.
  always_comb begin
    state_d     = state_q;
    de_d        = de_q;
    re_n_d      = re_n_q;
    d_d         = d_q;
    idle_cnt_d  = idle_cnt_q;
    guard_cnt_d = guard_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    case (state_q)
      LISTEN: begin
        if (!r_s) begin
          idle_cnt_d = '0;
        end else if (rx_idle && (idle_cnt_q != IDLE_MAX)) begin
          idle_cnt_d = idle_cnt_q + ICW'(1);
        end
        if (tx_valid && tx_ready) begin
          state_d     = LEAD;
          de_d        = 1'b1;
          re_n_d      = 1'b1;
          d_d         = 1'b1;
          guard_cnt_d = '0;
          idle_cnt_d  = '0;
          frame_d     = {1'b1, tx_data, 1'b0};
        end
      end
      LEAD: begin
        if (guard_cnt_q == LEAD_LAST) begin
          state_d   = SEND;
          d_d       = frame_q[0];
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + GCW'(1);
        end
      end
      SEND: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == FRAME_LAST) begin
            state_d     = TAIL;
            d_d         = 1'b1;
            guard_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
            d_d       = frame_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      TAIL: begin
        if (guard_cnt_q == TAIL_LAST) begin
          state_d    = LISTEN;
          de_d       = 1'b0;
          re_n_d     = 1'b0;
          d_d        = 1'b1;
          idle_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + GCW'(1);
        end
      end
      default: begin
        state_d = LISTEN;
        de_d    = 1'b0;
        re_n_d  = 1'b0;
        d_d     = 1'b1;
      end
    endcase
  end

  // Direction state and registered transceiver pins; reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LISTEN;
      de_q        <= 1'b0;
      re_n_q      <= 1'b0;
      d_q         <= 1'b1;
      idle_cnt_q  <= '0;
      guard_cnt_q <= '0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '1;
    end else begin
      state_q     <= state_d;
      de_q        <= de_d;
      re_n_q      <= re_n_d;
      d_q         <= d_d;
      idle_cnt_q  <= idle_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_q     <= frame_d;
    end
  end

  assign de   = de_q;
  assign re_n = re_n_q;
  assign d    = d_q;

endmodule

// File: tb/tb_rs485_hdx_ctrl.sv
// Bench for rs485_hdx_ctrl: directed sequence with randomised bytes,
// a waveform model for the transmitter and an expected-byte queue for RX.
module tb_rs485_hdx_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int DE_LEAD   = 3;
  localparam int DE_TAIL   = 4;
  localparam int IDLE_BITS = 2;
  localparam int QUIET     = IDLE_BITS * CLK_DIV;
  localparam int TX_LEN    = DE_LEAD + 10 * CLK_DIV + DE_TAIL;

  // ---------------- clock / reset / pins ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       de;
  logic       re_n;
  logic       d;
  logic       r_pin;
  logic       r_line = 1'b1;
  logic       noise = 1'b0;

  always #5 clk = ~clk;

  // Transceiver model: R is garbage while its receiver is disabled.
  assign r_pin = re_n ? noise : r_line;
  always @(posedge clk) noise <= 1'($urandom_range(0, 1));

  rs485_hdx_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .DE_LEAD   (DE_LEAD),
    .DE_TAIL   (DE_TAIL),
    .IDLE_BITS (IDLE_BITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .de           (de),
    .re_n         (re_n),
    .d            (d),
    .r            (r_pin)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         n_de = 0;
  int         last_valid_cyc = 0;
  int         ready_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect received bytes and pulse counts.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_data);
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (rx_frame_err === 1'b1) n_err++;
    if (de === 1'b1) n_de++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected D on each clock with DE high: lead ones, 8N1 frame bits, tail ones.
  function automatic logic tx_bit(input logic [7:0] b, input int i);
    int pos;
    if (i < DE_LEAD) return 1'b1;
    if (i >= DE_LEAD + 10 * CLK_DIV) return 1'b1;
    pos = (i - DE_LEAD) / CLK_DIV;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_ready !== 1'b1 && n < budget);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    r_line = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      r_line = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    r_line = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_check(input logic [7:0] b, input string tag);
    int n, w, bad, rn_bad, rdy_bad;
    tx_data  = b;
    tx_valid = 1'b1;
    if (tx_ready !== 1'b1) wait_ready(400, w);
    ready_cyc = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0; bad = 0; rn_bad = 0; rdy_bad = 0;
    while (de === 1'b1 && n < TX_LEN + 50) begin
      if (d !== tx_bit(b, n)) bad++;
      if (re_n !== 1'b1) rn_bad++;
      if (tx_ready !== 1'b0) rdy_bad++;
      n++;
      @(negedge clk);
    end
    check({tag, "_de_len"}, n, TX_LEN);
    check({tag, "_d_bits"}, bad, 0);
    check({tag, "_re_n_high"}, rn_bad, 0);
    check({tag, "_ready_low"}, rdy_bad, 0);
    check({tag, "_re_n_after"}, 32'(re_n), 0);
    check({tag, "_d_after"}, 32'(d), 1);
    wait_ready(200, w);
    check({tag, "_quiet_gap"}, w, QUIET);
  endtask

  task automatic rx_good(input logic [7:0] b, input string tag);
    int v0, e0;
    logic [7:0] g;
    v0 = n_valid;
    e0 = n_err;
    exp_q.push_back(b);
    drive_frame(b, 1'b1);
    r_line = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_valid_cnt"}, n_valid - v0, 1);
    check({tag, "_err_cnt"}, n_err - e0, 0);
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    check({tag, "_data"}, 32'(g), 32'(exp_q.pop_front()));
    check({tag, "_rx_data_held"}, 32'(rx_data), 32'(b));
    last_good = b;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, v0, e0, de0;
    logic [7:0] b, t;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_de", 32'(de), 0);
    check("rst_re_n", 32'(re_n), 0);
    check("rst_d", 32'(d), 1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    wait_ready(100, n);
    check("rst_ready_delay", n, QUIET);

    // Transmit: the fixed pattern, then random bytes
    send_check(8'hA5, "tx_a5");
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      send_check(b, "tx_rand");
    end

    // Receive good frames
    rx_good(8'h3C, "rx_3c");
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      rx_good(b, "rx_rand");
    end

    // Stop bit sampled low; line held low afterwards
    v0 = n_valid;
    e0 = n_err;
    drive_frame(8'h5A, 1'b0);
    r_line = 1'b0;
    repeat (20) @(negedge clk);
    check("ferr_err_cnt", n_err - e0, 1);
    check("ferr_valid_cnt", n_valid - v0, 0);
    check("ferr_rx_data_kept", 32'(rx_data), 32'(last_good));
    check("ferr_ready_low", 32'(tx_ready), 0);
    r_line = 1'b1;
    repeat (30) @(negedge clk);
    check("ferr_single_pulse", n_err - e0, 1);
    b = 8'($urandom_range(0, 255));
    rx_good(b, "rx_after_ferr");

    // Short low glitch: no pulses, quiet period restarts
    wait_ready(200, n);
    v0 = n_valid;
    e0 = n_err;
    r_line = 1'b0;
    repeat (2) @(negedge clk);
    r_line = 1'b1;
    wait_ready(100, n);
    check("glitch_ready_delay", 32'((n + 2 >= QUIET + 2) && (n + 2 <= QUIET + 4 + CLK_DIV / 2 + 2)), 1);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_err_cnt", n_err - e0, 0);

    // tx_valid raised in the cycle of the start edge: receive wins
    b = 8'($urandom_range(0, 255));
    t = 8'($urandom_range(0, 255));
    v0 = n_valid;
    de0 = n_de;
    exp_q.push_back(b);
    fork
      drive_frame(b, 1'b1);
      begin
        repeat (2) @(negedge clk);
        tx_data  = t;
        tx_valid = 1'b1;
        check("coll_ready_low", 32'(tx_ready), 0);
      end
    join
    r_line = 1'b1;
    check("coll_no_de", n_de - de0, 0);
    check("coll_valid_cnt", n_valid - v0, 1);
    check("coll_data", 32'((got_q.size() > 0) ? got_q.pop_front() : 8'hxx), 32'(exp_q.pop_front()));
    send_check(t, "coll_tx");
    check("coll_ready_after_rx", ready_cyc - last_valid_cyc, QUIET);

    // Reset in the middle of a transmitted frame
    tx_data  = 8'($urandom_range(0, 255));
    tx_valid = 1'b1;
    if (tx_ready !== 1'b1) wait_ready(200, n);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (DE_LEAD + 20) @(negedge clk);
    check("mid_send_de", 32'(de), 1);
    v0 = n_valid;
    e0 = n_err;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_de", 32'(de), 0);
    check("async_rst_re_n", 32'(re_n), 0);
    check("async_rst_d", 32'(d), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(100, n);
    check("send_rst_ready_delay", n, QUIET);
    check("send_rst_no_valid", n_valid - v0, 0);
    check("send_rst_no_err", n_err - e0, 0);

    // Reset in the middle of a received frame: partial byte discarded
    v0 = n_valid;
    e0 = n_err;
    fork
      drive_frame(8'($urandom_range(0, 255)), 1'b1);
      begin
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    r_line = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(100, n);
    check("rx_rst_ready_delay", n, QUIET);
    check("rx_rst_no_valid", n_valid - v0, 0);
    check("rx_rst_no_err", n_err - e0, 0);
    check("rx_rst_rx_data", 32'(rx_data), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs485_hdx_ctrl.md
# rs485_hdx_ctrl

Half-duplex RS-485 link controller that sequences one LVD207-class transceiver on a shared two-wire bus. It owns the driver-enable (DE), receiver-enable (RE_n), driver data (D) and receiver data (R) pins. It serialises bytes as UART 8N1 frames with programmable DE lead and tail guard times, and deserialises incoming frames. It arbitrates bus direction, so transmit starts only after the bus has been quiet for a configured time and reception always has priority.

## Interface
Parameters:
- CLK_DIV, 868 — clocks per bit, ≥4; 100 MHz / 115200 baud.
- DE_LEAD, 100 — clocks DE is high with D=1 before the start bit, ≥1.
- DE_TAIL, 100 — clocks DE stays high with D=1 after the stop bit ends, ≥1.
- IDLE_BITS, 2 — bit times of quiet receive line required before TX may start, ≥1.

Ports:
- clk  in  1 — single clock.
- rst_n  in  1 — reset, asynchronous, active-low.
- tx_data  in  8 — byte to send.
- tx_valid  in  1 — transmit request.
- tx_ready  out  1 — controller accepts tx_data this cycle.
- rx_data  out  8 — received byte, held until the next rx_valid.
- rx_valid  out  1 — 1-cycle pulse, good frame received.
- rx_frame_err  out  1 — 1-cycle pulse, stop bit sampled as 0.
- de  out  1 — transceiver DE.
- re_n  out  1 — transceiver RE_n.
- d  out  1 — transceiver D.
- r  in  1 — transceiver R; asynchronous; undefined (Z) while re_n=1.

## Operation
Reset values: de=0, re_n=0, d=1, tx_ready=0, rx_valid=0, rx_frame_err=0, rx_data=8'h00, both FSMs idle, idle counter cleared.

Input conditioning:
- r passes through a 2-flop synchroniser to give r_s, with 2 clocks of latency.
- While re_n=1, r_s is forced to 1, so Z is never interpreted as data.

Direction FSM has four states: LISTEN, LEAD, SEND, TAIL.
- LISTEN: de=0, re_n=0. The idle counter increments while r_s=1 and the RX FSM is idle, saturating at IDLE_BITS*CLK_DIV. It clears on r_s=0.
  - tx_ready = LISTEN && counter saturated && RX idle && no falling edge of r_s this cycle.
  - tx_valid && tx_ready latches tx_data and moves to LEAD.
- LEAD: de=1, re_n=1, d=1 for DE_LEAD clocks, then SEND.
- SEND: the 10-bit frame is start(0), data bits 0..7 (LSB first), stop(1). Each bit drives d for exactly CLK_DIV clocks, then TAIL.
- TAIL: de=1, re_n=1, d=1 for DE_TAIL clocks, then LISTEN with de=0 and re_n=0. The idle counter is cleared on LISTEN entry, so a full quiet period is required before the next byte.
- tx_ready=0 in every state except LISTEN. The controller holds no second TX buffer.

RX FSM has four states: R_IDLE, R_START, R_DATA, R_STOP. It is active only in LISTEN.
- A falling edge of r_s in R_IDLE moves to R_START.
- At CLK_DIV/2 (floor), r_s is checked:
  - r_s=1: false start; return to R_IDLE with no pulse.
  - r_s=0: move to R_DATA.
- Each data bit is sampled one CLK_DIV after the previous sample, at mid-bit, LSB first.
- R_STOP samples the stop bit at mid-bit:
  - 1: rx_data is updated and rx_valid pulses on the same clock edge, then R_IDLE.
  - 0: rx_frame_err pulses, rx_data is unchanged, and the FSM waits for r_s=1 before R_IDLE.

Simultaneous events:
- A falling edge and tx_valid in the same cycle: RX wins, because tx_ready is already 0.
- Reset asserted mid-frame: de=0, re_n=0, d=1 immediately (asynchronous). The partial byte is discarded and no pulse is issued.

## Timing
- Handshake at edge N: de=1 and re_n=1 from edge N+1.
- The start bit begins at edge N+1+DE_LEAD.
- de falls at edge N+1+DE_LEAD+10·CLK_DIV+DE_TAIL.
- The earliest next tx_ready is IDLE_BITS·CLK_DIV clocks later.
- RX latency: rx_valid asserts 2 (sync) + CLK_DIV/2 + 9·CLK_DIV clocks after the falling edge of r. The count in clocks may vary by one, due to edge sampling.
- Counters:
  - Bit counter: ceil(log2(CLK_DIV)) bits.
  - Bit index: 4 bits.
  - Guard counters: ceil(log2(max(DE_LEAD, DE_TAIL)+1)) bits.
  - Idle counter: ceil(log2(IDLE_BITS·CLK_DIV+1)) bits.
  - No counter wraps; all compare to terminal count and reload.

## Structure
- Package rs485_pkg holds:
  - dir_state_t {LISTEN, LEAD, SEND, TAIL} and rx_state_t {R_IDLE, R_START, R_DATA, R_STOP}.
  - Constants FRAME_BITS=10 and DATA_BITS=8.
  - A clog2-based width function.
- Sub-module rs485_rx_deser contains the synchroniser, RX FSM, and the rx_data/rx_valid/rx_frame_err outputs. It exports rx_idle and r_s to the top-level direction FSM.

## Test plan
Benches use CLK_DIV=8, DE_LEAD=3, DE_TAIL=4, IDLE_BITS=2. Each line is stimulus -> required response.
- Reset, then r held at 1 -> tx_ready rises 16 clocks after reset release. Send 8'hA5 -> de high for 3+80+4 clocks; d pattern 1,1,1,0,1,0,1,0,0,1,0,1,1,1,1,1, each bit 8 clocks; then de=0, re_n=0.
- Model transceiver drives frame 8'h3C on r -> rx_valid pulses once with rx_data=8'h3C; rx_frame_err=0.
- Frame with stop=0 -> rx_frame_err pulses, rx_valid stays 0, rx_data is unchanged; no new start is accepted until r returns to 1.
- A 2-clock low glitch on r -> no pulses, FSM returns to R_IDLE, and the idle counter restarts.
- tx_valid asserted in the same cycle as the r falling edge -> tx_ready=0 and the frame is received. TX starts only after the frame plus 16 quiet clocks.
- rst_n pulsed low mid-SEND -> de=0, re_n=0, d=1 within the reset cycle; after release, no stale rx_valid and tx_ready follows the idle rule.
